// File: rtl/gpio_port_irq_if.sv
// Peripheral register bus for gpio_port_irq: write strobe, address and data in, combinational read data out.
// The master drives the write side. The slave returns o_rdata for whatever i_addr currently selects.
interface gpio_port_irq_if #(parameter int WIDTH = 16);
  logic             i_we;
  logic [2:0]       i_addr;
  logic [WIDTH-1:0] i_wdata;
  logic [WIDTH-1:0] o_rdata;

  modport master (output i_we, i_addr, i_wdata, input o_rdata);
  modport slave  (input i_we, i_addr, i_wdata, output o_rdata);
endinterface

// File: rtl/gpio_port_irq.sv
// GPIO port with tri-state pads, synchronised inputs, edge-triggered sticky W1C status and a maskable registered IRQ.
// Reads are combinational and writes complete in one cycle, so there is no backpressure. STATUS is set SYNC_STAGES+1 edges after a pin change; o_irq follows one edge later.
module gpio_port_irq #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  gpio_port_irq_if.slave   bus,
  inout  wire  [WIDTH-1:0] io_pins,
  output logic             o_irq
);

  localparam logic [2:0] A_DIR     = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_IRQ_EN  = 3'd3;
  localparam logic [2:0] A_RISE_EN = 3'd4;
  localparam logic [2:0] A_FALL_EN = 3'd5;
  localparam logic [2:0] A_STATUS  = 3'd6;

  logic [WIDTH-1:0] r_dir, r_out, r_irq_en, r_rise_en, r_fall_en, r_status, r_prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic             r_irq;

  logic [WIDTH-1:0] w_in, w_rise, w_fall, w_evt, w_clr;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign io_pins[g] = r_dir[g] ? r_out[g] : 1'bz;
  end

  assign w_in   = r_sync[SYNC_STAGES-1];
  assign w_rise = w_in & ~r_prev;
  assign w_fall = ~w_in & r_prev;
  assign w_evt  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr  = (bus.i_we && bus.i_addr == A_STATUS) ? bus.i_wdata : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_irq_en  <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (bus.i_we) begin
      case (bus.i_addr)
        A_DIR:     r_dir     <= bus.i_wdata;
        A_OUT:     r_out     <= bus.i_wdata;
        A_IRQ_EN:  r_irq_en  <= bus.i_wdata;
        A_RISE_EN: r_rise_en <= bus.i_wdata;
        A_FALL_EN: r_fall_en <= bus.i_wdata;
        default: ;
      endcase
    end
  end

  // A new event wins over a same-cycle clear so no edge is ever lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], io_pins};
      r_prev   <= w_in;
      r_status <= (r_status & ~w_clr) | w_evt;
      r_irq    <= |(r_status & r_irq_en);
    end
  end

  assign o_irq = r_irq;

  always_comb begin
    bus.o_rdata = '0;
    case (bus.i_addr)
      A_DIR:     bus.o_rdata = r_dir;
      A_OUT:     bus.o_rdata = r_out;
      A_IN:      bus.o_rdata = w_in;
      A_IRQ_EN:  bus.o_rdata = r_irq_en;
      A_RISE_EN: bus.o_rdata = r_rise_en;
      A_FALL_EN: bus.o_rdata = r_fall_en;
      A_STATUS:  bus.o_rdata = r_status;
      default:   bus.o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_port_irq.sv
// Self-checking bench for gpio_port_irq: register table plus latency, mask, set/clear race and async reset sequences.
module tb_gpio_port_irq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] tb_en, tb_val;
  wire  [W-1:0] pins;
  wire          irq;

  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pins[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  gpio_port_irq_if #(.WIDTH(W)) bus();

  gpio_port_irq #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave),
    .io_pins (pins),
    .o_irq   (irq)
  );

  typedef struct {
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl[6];
  logic [W-1:0] sb_q[$];
  int           errs = 0;
  int           checks = 0;
  logic [W-1:0] v;

  task automatic sb_push(input logic [W-1:0] e);
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errs++;
      $display("FAIL %s: no expected value queued, got %h", name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        errs++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus.i_we    = 1'b1;
    bus.i_addr  = a;
    bus.i_wdata = d;
    @(posedge clk);
    #1;
    bus.i_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
    bus.i_addr = a;
    #1;
    d = bus.o_rdata;
  endtask

  function automatic logic [W-1:0] ext(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  initial begin
    tbl[0] = '{3'd1, 16'hAAAA, 16'hAAAA};
    tbl[1] = '{3'd3, 16'h1234, 16'h1234};
    tbl[2] = '{3'd4, 16'hF0F0, 16'hF0F0};
    tbl[3] = '{3'd5, 16'h0F0F, 16'h0F0F};
    tbl[4] = '{3'd7, 16'hFFFF, 16'h0000};
    tbl[5] = '{3'd2, 16'h0000, 16'hFFFF};

    bus.i_we = 1'b0; bus.i_addr = 3'd0; bus.i_wdata = '0;
    tb_en = 16'hFFFF; tb_val = 16'hFFFF;

    // Reset with pins pulled high externally
    repeat (3) tick();
    sb_push(ext(1'b0)); sb_check("rst_irq", ext(irq));
    sb_push(16'hFFFF);  sb_check("rst_pins_hiz", pins);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      sb_push('0); sb_check($sformatf("rst_reg%0d", a), v);
    end
    rst_n = 1'b1;
    tick(); tick();
    rd(3'd2, v); sb_push(16'hFFFF); sb_check("rst_in_after_release", v);

    for (int i = 0; i < 6; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      sb_push(tbl[i].exp);
      rd(tbl[i].addr, v);
      sb_check($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), v);
    end
    wr(3'd3, '0); wr(3'd4, '0); wr(3'd5, '0);
    rd(3'd6, v); sb_push('0); sb_check("tbl_no_spurious_status", v);

    // Output drive with external upper byte
    tb_en = 16'hFF00; tb_val = 16'h7500;
    wr(3'd1, 16'hAAAA);
    wr(3'd0, 16'h00FF);
    sb_push(16'h75AA); sb_check("out_pins", pins);
    tick(); tick();
    rd(3'd2, v); sb_push(16'h75AA); sb_check("out_in_readback", v);

    // Rising edge latency on pin0
    wr(3'd4, 16'h0001); wr(3'd3, 16'h0001);
    wr(3'd1, 16'hAAAB);
    sb_push('0); sb_push(16'h75AB); sb_push('0);
    sb_push(16'h0001); sb_push(ext(1'b0)); sb_push(ext(1'b1));
    tick(); rd(3'd6, v); sb_check("rise_status_e1", v);
    tick(); rd(3'd2, v); sb_check("rise_in_e2", v);
    rd(3'd6, v); sb_check("rise_status_e2", v);
    tick(); rd(3'd6, v); sb_check("rise_status_e3", v);
    sb_check("rise_irq_e3", ext(irq));
    tick(); sb_check("rise_irq_e4", ext(irq));
    wr(3'd6, 16'h0001);
    rd(3'd6, v); sb_push('0); sb_check("w1c_status", v);
    sb_push(ext(1'b1)); sb_check("w1c_irq_same_edge", ext(irq));
    tick(); sb_push(ext(1'b0)); sb_check("w1c_irq_next_edge", ext(irq));

    // Falling edge on pin15 with interrupt masked
    wr(3'd4, '0); wr(3'd3, '0);
    tb_val = 16'hF500;
    repeat (4) tick();
    wr(3'd5, 16'h8000);
    tb_val = 16'h7500;
    repeat (3) tick();
    rd(3'd6, v); sb_push(16'h8000); sb_check("fall_status", v);
    sb_push(ext(1'b0)); sb_check("fall_irq_masked", ext(irq));
    tick(); sb_push(ext(1'b0)); sb_check("fall_irq_still_masked", ext(irq));
    wr(3'd3, 16'h8000);
    sb_push(ext(1'b0)); sb_check("unmask_irq_same_edge", ext(irq));
    tick(); sb_push(ext(1'b1)); sb_check("unmask_irq_next_edge", ext(irq));
    wr(3'd6, 16'hFFFF); wr(3'd5, '0); wr(3'd3, '0);

    // Clear landing on the same edge as a new rise
    wr(3'd4, 16'h0001); wr(3'd3, 16'h0001);
    wr(3'd1, 16'hAAAA); repeat (4) tick();
    wr(3'd1, 16'hAAAB); repeat (4) tick();
    rd(3'd6, v); sb_push(16'h0001); sb_check("race_pre_status", v);
    sb_push(ext(1'b1)); sb_check("race_pre_irq", ext(irq));
    wr(3'd1, 16'hAAAA); repeat (4) tick();
    wr(3'd1, 16'hAAAB);
    tick(); tick();
    wr(3'd6, 16'h0001);
    rd(3'd6, v); sb_push(16'h0001); sb_check("race_status_kept", v);
    tick(); sb_push(ext(1'b1)); sb_check("race_irq_kept", ext(irq));
    wr(3'd6, 16'h0001);
    rd(3'd6, v); sb_push('0); sb_check("race_later_clear", v);
    tick(); sb_push(ext(1'b0)); sb_check("race_irq_drop", ext(irq));

    // Asynchronous reset between edges
    wr(3'd4, 16'h0003); wr(3'd3, 16'h0003);
    wr(3'd1, 16'hAAA8); repeat (4) tick();
    wr(3'd6, 16'hFFFF);
    wr(3'd1, 16'hAAAB); repeat (5) tick();
    rd(3'd6, v); sb_push(16'h0003); sb_check("mid_pre_status", v);
    sb_push(ext(1'b1)); sb_check("mid_pre_irq", ext(irq));
    #2;
    rst_n = 1'b0;
    #1;
    sb_push(ext(1'b0)); sb_check("mid_rst_irq", ext(irq));
    tb_en = 16'hFFFF; tb_val = 16'h7555;
    #1;
    sb_push(16'h7555); sb_check("mid_rst_pins_hiz", pins);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      sb_push('0); sb_check($sformatf("mid_rst_reg%0d", a), v);
    end
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
